// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered ALU with valid/ready handshakes, NZCV flags and an
// iterative one-bit-per-cycle shifter.
//
// Sits between register-read and writeback. An operation is accepted in IDLE.
// Non-shift ops and zero-amount shifts produce a result one cycle later. Other
// shifts walk through SHIFT for min(amt, WIDTH) cycles. The result is held in
// DONE until the consumer takes it, so the ALU can stall the pipe.
//
// Parameters:
//   WIDTH      datapath width (must be >= IMM_WIDTH + 1)
//   IMM_WIDTH  immediate width; immediates are zero-extended to WIDTH
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operation presented            in_ready   high only in IDLE
//   op1, op2   register operands              imm_mode   1: op2 <- zext(imm)
//   imm        immediate / shift amount       alu_mode   1: arith/logic, 0: move/shift
//   alu_func   function code
//   out_valid  result/flags valid (DONE)      out_ready  consumer accepts result
//   result     registered result              flags      {N,Z,C,V}
//   busy       high while shifting
//
// Optional build macro:
//   ALU_ASR_EN  when defined, alu_mode=0/alu_func=111 is an arithmetic right
//               shift (sign fill). Otherwise 111 behaves exactly as LSR.
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
    input  logic                 imm_mode,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic                 alu_mode,
    input  logic [2:0]           alu_func,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [3:0]           flags,
    output logic                 busy
);

    localparam int SHW = $clog2(WIDTH) + 1;
    // Common width for comparing the raw immediate against WIDTH.
    localparam int CW  = (IMM_WIDTH > SHW) ? IMM_WIDTH : SHW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;
    logic [WIDTH-1:0] result_reg;
    logic [3:0]       flags_reg;

    // Shifter working state
    logic [WIDTH-1:0] sh_reg;
    logic [SHW-1:0]   cnt_reg;
    logic             dir_reg;     // 1: right, 0: left
    logic             arith_reg;   // sign fill on right shifts
    logic             over_reg;    // requested amount exceeded WIDTH

    // -------------------------------------------------------------------------
    // Operand preparation
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] op2_eff;
    logic [CW-1:0]    imm_cw;
    logic             amt_sat;
    logic             amt_over;
    logic [SHW-1:0]   amt;
    logic             is_shift;
    logic             is_asr;

    assign imm_ext  = WIDTH'(imm);
    assign op2_eff  = imm_mode ? imm_ext : op2;
    assign imm_cw   = CW'(imm);
    assign amt_sat  = (imm_cw >= CW'(WIDTH));
    assign amt_over = (imm_cw >  CW'(WIDTH));
    assign amt      = amt_sat ? SHW'(WIDTH) : SHW'(imm_cw);
    assign is_shift = !alu_mode && alu_func[2];

`ifdef ALU_ASR_EN
    assign is_asr = (alu_func == 3'b111);
`else
    assign is_asr = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Single-cycle ops (also covers zero-amount shifts, which pass op1)
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign add_full = {1'b0, op1} + {1'b0, op2_eff};
    // The extra top bit of the difference is the borrow (op1 < op2 unsigned).
    assign sub_full = {1'b0, op1} - {1'b0, op2_eff};

    always_comb begin
        alu_res = op1;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        if (alu_mode) begin
            case (alu_func)
                3'b001: begin
                    alu_res = add_full[WIDTH-1:0];
                    alu_c   = add_full[WIDTH];
                    alu_v   = (op1[WIDTH-1] == op2_eff[WIDTH-1]) &&
                              (alu_res[WIDTH-1] != op1[WIDTH-1]);
                end
                3'b010: begin
                    alu_res = sub_full[WIDTH-1:0];
                    alu_c   = sub_full[WIDTH];
                    alu_v   = (op1[WIDTH-1] != op2_eff[WIDTH-1]) &&
                              (alu_res[WIDTH-1] != op1[WIDTH-1]);
                end
                3'b011:  alu_res = op1 & op2_eff;
                3'b100:  alu_res = op1 | op2_eff;
                3'b101:  alu_res = op1 ^ op2_eff;
                3'b110:  alu_res = ~op1;
                default: alu_res = op1;
            endcase
        end else begin
            case (alu_func)
                3'b000:  alu_res = imm_ext;
                3'b001:  alu_res = {imm, op1[WIDTH-IMM_WIDTH-1:0]};
                3'b010:  alu_res = '0;
                3'b011:  alu_res = '1;
                default: alu_res = op1;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // One-bit shift step
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sh_next;
    logic             fill_bit;
    logic             c_out;
    logic             shift_c;

    assign fill_bit = dir_reg & arith_reg & sh_reg[WIDTH-1];
    assign c_out    = dir_reg ? sh_reg[0] : sh_reg[WIDTH-1];
    // Logical shifts past WIDTH lose every bit, so the carry is cleared; an
    // arithmetic shift keeps shifting out copies of the sign bit.
    assign shift_c  = (over_reg && !arith_reg) ? 1'b0 : c_out;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift_bit
            if (gi == 0) begin : g_lsb
                assign sh_next[gi] = dir_reg ? sh_reg[gi+1] : 1'b0;
            end else if (gi == WIDTH-1) begin : g_msb
                assign sh_next[gi] = dir_reg ? fill_bit : sh_reg[gi-1];
            end else begin : g_mid
                assign sh_next[gi] = dir_reg ? sh_reg[gi+1] : sh_reg[gi-1];
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            result_reg    <= '0;
            flags_reg     <= 4'b0000;
            sh_reg        <= '0;
            cnt_reg       <= '0;
            dir_reg       <= 1'b0;
            arith_reg     <= 1'b0;
            over_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_reg <= 1'b0;
                        if (is_shift && (amt != '0)) begin
                            state_reg <= SHIFT;
                            busy_reg  <= 1'b1;
                            sh_reg    <= op1;
                            cnt_reg   <= amt;
                            dir_reg   <= alu_func[0];
                            arith_reg <= is_asr;
                            over_reg  <= amt_over;
                        end else begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            result_reg    <= alu_res;
                            flags_reg     <= {alu_res[WIDTH-1], (alu_res == '0),
                                              alu_c, alu_v};
                        end
                    end
                end
                SHIFT: begin
                    // The last step writes the result directly so DONE
                    // follows exactly min(amt, WIDTH) cycles after accept.
                    if (cnt_reg == SHW'(1)) begin
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                        result_reg    <= sh_next;
                        flags_reg     <= {sh_next[WIDTH-1], (sh_next == '0),
                                          shift_c, 1'b0};
                    end else begin
                        sh_reg  <= sh_next;
                        cnt_reg <= cnt_reg - SHW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign result    = result_reg;
    assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (default WIDTH=32, IMM_WIDTH=16).
// Directed cases plus randomized operations, checked against a behavioural
// model that derives results, flags and latency with plain wide arithmetic.
// Honours ALU_ASR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_seq;

`ifdef ALU_ASR_EN
    localparam bit ASR_EN = 1'b1;
`else
    localparam bit ASR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        imm_mode = 1'b0;
    logic [15:0] imm = '0;
    logic        alu_mode = 1'b0;
    logic [2:0]  alu_func = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ops    = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .IMM_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .imm_mode  (imm_mode),
        .imm       (imm),
        .alu_mode  (alu_mode),
        .alu_func  (alu_func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: result, flags {N,Z,C,V} and accept-to-valid latency.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic im, input logic [15:0] iv,
                                  input logic md, input logic [2:0] fn,
                                  output logic [31:0] r, output logic [3:0] f,
                                  output int lat);
        logic [31:0] e2;
        logic [63:0] w;
        logic        c;
        logic        v;
        longint      sa;
        int          amt;
        e2  = im ? {16'h0, iv} : b;
        c   = 1'b0;
        v   = 1'b0;
        lat = 1;
        r   = a;
        amt = int'(iv);
        if (amt > 63) amt = 63;
        if (md) begin
            case (fn)
                3'd1: begin
                    w  = {32'h0, a} + {32'h0, e2};
                    r  = w[31:0];
                    c  = w[32];
                    sa = longint'($signed(a)) + longint'($signed(e2));
                    v  = (sa != longint'($signed(r)));
                end
                3'd2: begin
                    r  = a - e2;
                    c  = (a < e2);
                    sa = longint'($signed(a)) - longint'($signed(e2));
                    v  = (sa != longint'($signed(r)));
                end
                3'd3:    r = a & e2;
                3'd4:    r = a | e2;
                3'd5:    r = a ^ e2;
                3'd6:    r = ~a;
                default: r = a;
            endcase
        end else begin
            case (fn)
                3'd0: r = {16'h0, iv};
                3'd1: r = {iv, a[15:0]};
                3'd2: r = 32'h0;
                3'd3: r = 32'hFFFF_FFFF;
                default: begin
                    lat = 1 + ((iv > 16'd32) ? 32 : int'(iv));
                    if (fn[0] == 1'b0) begin
                        w = {32'h0, a} << amt;
                        r = w[31:0];
                        c = w[32];
                    end else if (fn == 3'd7 && ASR_EN) begin
                        w = $signed({a, 32'h0}) >>> amt;
                        r = w[63:32];
                        c = w[31];
                    end else begin
                        w = {a, 32'h0} >> amt;
                        r = w[63:32];
                        c = w[31];
                    end
                end
            endcase
        end
        f = {r[31], (r == 32'h0), c, v};
    endfunction

    // Issue one op, wait for its result, hold it for 'hold' cycles, retire it.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic im,
                          input logic [15:0] iv, input logic md, input logic [2:0] fn,
                          input int hold);
        logic [31:0] er;
        logic [3:0]  ef;
        int          el;
        int          lat;
        int          bcnt;
        model(a, b, im, iv, md, fn, er, ef, el);
        check("in_ready_idle", in_ready, 1);
        op1 = a; op2 = b; imm_mode = im; imm = iv; alu_mode = md; alu_func = fn;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        // Scramble the op fields: the ALU must have latched them.
        in_valid = 1'b0;
        op1 = $urandom; op2 = $urandom; imm = 16'($urandom);
        imm_mode = 1'($urandom); alu_mode = 1'($urandom); alu_func = 3'($urandom);
        lat  = 1;
        bcnt = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check("latency", lat, el);
        check("busy_cycles", bcnt, el - 1);
        check("result", result, er);
        check("flags", flags, ef);
        check("in_ready_done", in_ready, 0);
        repeat (hold) @(negedge clk);
        check("result_held", result, er);
        check("out_valid_held", out_valid, 1);
        $display("op %0d: mode=%0d func=%0d op1=%h op2=%h imm_mode=%0d imm=%h -> result=%h flags=%b lat=%0d (exp %h %b %0d)",
                 n_ops, md, fn, a, b, im, iv, result, flags, lat, er, ef, el);
        n_ops++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after", in_ready, 1);
        check("out_valid_after", out_valid, 0);
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] riv;
        logic [31:0] ra;
        int          sel;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ADD overflow into sign bit
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 16'h0, 1'b1, 3'd1, 0);
        // SUB with immediate: equal, then borrow
        run_op(32'd5, 32'hDEAD, 1'b1, 16'd5, 1'b1, 3'd2, 1);
        run_op(32'd3, 32'hDEAD, 1'b1, 16'd5, 1'b1, 3'd2, 0);
        // LSL by 4, LSR by 0
        run_op(32'h8000_0001, 32'h0, 1'b0, 16'd4, 1'b0, 3'd4, 0);
        run_op(32'h8000_0001, 32'h0, 1'b0, 16'd0, 1'b0, 3'd5, 0);
        // MOVT held for 3 cycles
        run_op(32'h1234_ABCD, 32'h0, 1'b0, 16'hBEEF, 1'b0, 3'd1, 3);
        // Shift boundaries around WIDTH
        run_op(32'h8000_0001, 32'h0, 1'b0, 16'd32, 1'b0, 3'd4, 0);
        run_op(32'h8000_0001, 32'h0, 1'b0, 16'd32, 1'b0, 3'd5, 0);
        run_op(32'h8000_0001, 32'h0, 1'b0, 16'd33, 1'b0, 3'd6, 0);
        run_op(32'h8000_0001, 32'h0, 1'b0, 16'hFFFF, 1'b0, 3'd7, 0);
        // Func 111 with MSB set, amount 31 (ASR vs LSR)
        run_op(32'h8000_0000, 32'h0, 1'b0, 16'd31, 1'b0, 3'd7, 0);
        run_op(32'h8000_0000, 32'h0, 1'b0, 16'd40, 1'b0, 3'd7, 0);

        // Reset in the middle of a long shift
        op1 = 32'hF0F0_1234; imm = 16'd20; alu_mode = 1'b0; alu_func = 3'd5;
        imm_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midshift_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_flags", flags, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("op %0d: reset applied mid-shift", n_ops);
        n_ops++;

        // Randomized operations
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0:       riv = 16'd0;
                1:       riv = 16'($urandom_range(1, 31));
                2:       riv = 16'd32;
                3:       riv = 16'd33;
                4:       riv = 16'($urandom);
                default: riv = 16'($urandom_range(0, 40));
            endcase
            case ($urandom_range(0, 3))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'h7FFF_FFFF;
                default: ra = $urandom;
            endcase
            run_op(ra, $urandom, 1'($urandom), riv, 1'($urandom), 3'($urandom),
                   $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the single-cycle datapath ALU. It has a valid/ready handshake on input and output, NZCV flags with correct per-op carry/overflow, and an iterative one-bit-per-cycle shifter. It sits between register-read and writeback in the core. A result is held until writeback accepts it, so the ALU can stall the pipe on long shifts.

Parameters:
WIDTH, 32, datapath width in bits (>= IMM_WIDTH + 1)
IMM_WIDTH, 16, immediate field width; immediates are zero-extended to WIDTH
SHW (localparam), $clog2(WIDTH)+1, shift-counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operation presented
in_ready  out  1  ALU can accept (high only in IDLE)
op1  in  WIDTH  first register operand
op2  in  WIDTH  second register operand
imm_mode  in  1  1: op2 replaced by zero-extended imm
imm  in  IMM_WIDTH  immediate / shift amount
alu_mode  in  1  1: arithmetic/logic group; 0: move/shift group
alu_func  in  3  function code
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
flags  out  4  {N,Z,C,V} = flags[3:0] registered
busy  out  1  high in SHIFT state

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, busy=0. An in-flight op is discarded.
- States:
  - IDLE: accept on in_valid&in_ready, latching operands/func. Non-shift ops, or shifts with amount 0, go to DONE next edge. Other shifts go to SHIFT.
  - SHIFT: one bit per cycle; counter decrements to 0, then DONE.
  - DONE: out_valid=1; result/flags stable. On out_ready, go to IDLE. No new op is accepted in the same cycle.
- Latency from accept to out_valid:
  - 1 cycle for non-shift ops.
  - 1 + min(amt, WIDTH) cycles for shifts.
  - amt = imm, saturated to WIDTH.
- op2 effective = imm_mode ? zero-extend(imm) : op2.
- alu_mode=1 functions:
  - 001 ADD: op1+op2; C = carry out; V = operands same sign and result sign differs.
  - 010 SUB: op1-op2; C = 1 iff borrow (op1 < op2 unsigned); V = operand signs differ and result sign != op1 sign.
  - 011 AND, 100 OR, 101 XOR: bitwise with op2.
  - 110 NOT: ~op1.
  - 000 and 111: result = op1 (pass).
  - Logic/NOT/pass ops: C=V=0.
- alu_mode=0 functions:
  - 000 MOV: result = zero-extend(imm).
  - 001 MOVT: result = {imm, op1[WIDTH-IMM_WIDTH-1:0]}, i.e. the upper field is replaced and the low bits preserved.
  - 010 CLR: result = 0.
  - 011 SET: result = all ones.
  - 1x0 LSL, 1x1 LSR: shift op1 by amt.
  - Shifts: C = last bit shifted out (0 if amt=0); V=0.
  - amt >= WIDTH: result 0; C = op1 LSB/MSB only if amt == WIDTH exactly, else 0.
  - MOV/MOVT/CLR/SET: C=V=0.
- All ops: N = result[WIDTH-1]; Z = 1 iff result == 0.
- Inputs are ignored when in_ready=0; op fields may change freely after accept.

Optional Feature:
ALU_ASR_EN:
- Defined: alu_mode=0, alu_func=111 is ASR (sign fill from op1 MSB). For amt >= WIDTH, result = all copies of MSB, and C = MSB. alu_func=101 remains LSR.
- Undefined: 111 behaves exactly as LSR.

Test Plan:
1. ADD op1=0x7FFFFFFF, op2=1 -> after 1 cycle, result=0x80000000, flags N=1 Z=0 C=0 V=1.
2. SUB imm_mode=1, op1=5, imm=5 -> result=0, Z=1, C=0, V=0. Then op1=3, imm=5 -> result=0xFFFFFFFE, N=1, C=1.
3. LSL op1=0x80000001, imm=4 -> busy 4 cycles, out_valid on 5th cycle, result=0x00000010, C=0. LSR imm=0 -> 1-cycle latency, result=op1, C=0.
4. Hold out_ready=0 for 3 cycles after MOVT op1=0x1234ABCD, imm=0xBEEF -> result stays 0xBEEFABCD, in_ready=0. Assert out_ready -> in_ready=1 the next cycle.
5. Assert rst mid-SHIFT (LSR imm=20, 10 cycles in) -> immediately out_valid=0, result=0, flags=0, in_ready=1, busy=0.
6. ALU_ASR_EN defined: func 111, op1=0x80000000, imm=31 -> result=0xFFFFFFFF, N=1, C=0. Undefined -> result=0x00000001.
